// File: rtl/xmit_frame_feeder_pkg.sv
// Shared types and constants for the transmit frame feeder.
// Holds the state encoding and control-word layout.
package xmit_pkg;

    localparam int CTRL_W = 24;
    localparam int LEN_W  = 12;

    localparam int CTRL_LEN_HI = 23;
    localparam int CTRL_LEN_LO = 12;
    localparam int CTRL_CPY_HI = 11;
    localparam int CTRL_CPY_LO = 0;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FLUSH,
        GAP
    } state_t;

    function automatic logic [CTRL_W-1:0] make_ctrl(
        input logic [LEN_W-1:0] len
    );
        logic [CTRL_W-1:0] c;
        c = '0;
        c[CTRL_LEN_HI:CTRL_LEN_LO] = len;
        c[CTRL_CPY_HI:CTRL_CPY_LO] = len;
        return c;
    endfunction

    function automatic logic len_legal(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] lo,
        input logic [LEN_W-1:0] hi
    );
        return (len >= lo) && (len <= hi);
    endfunction

endpackage

// File: rtl/xmit_frame_feeder_if.sv
// Upstream byte stream plus the registered feed toward the xmit stage.
// master = source/sink side, slave = the feeder itself.
interface xmit_frame_feeder_if;
    import xmit_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_sop;
    logic             s_eop;
    logic [LEN_W-1:0] s_len;
    logic             s_hi_pri;

    logic [7:0]        f_data_in;
    logic              f_rec_data_valid;
    logic              f_rec_frame_valid;
    logic [CTRL_W-1:0] f_ctrl_in;
    logic              f_hi_priority;

    logic m_discard_en;

    modport master (
        output s_valid,
        output s_data,
        output s_sop,
        output s_eop,
        output s_len,
        output s_hi_pri,
        output m_discard_en,
        input  s_ready,
        input  f_data_in,
        input  f_rec_data_valid,
        input  f_rec_frame_valid,
        input  f_ctrl_in,
        input  f_hi_priority
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_sop,
        input  s_eop,
        input  s_len,
        input  s_hi_pri,
        input  m_discard_en,
        output s_ready,
        output f_data_in,
        output f_rec_data_valid,
        output f_rec_frame_valid,
        output f_ctrl_in,
        output f_hi_priority
    );

endinterface

// File: rtl/xmit_frame_feeder_sat_counter16.sv
// 16-bit event counter that sticks at all-ones.
// Used for every feeder statistic.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/xmit_frame_feeder.sv
// Feeds length-checked frames to the xmit stage, padding short frames,
// trimming long ones and enforcing an inter-frame gap.
module xmit_frame_feeder
    import xmit_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 2047,
    parameter int IFG     = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    xmit_frame_feeder_if.slave bus,
    output logic [15:0] cnt_sent,
    output logic [15:0] cnt_dropped,
    output logic [15:0] cnt_discard
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [GW-1:0] GAP_LD =
        GW'((IFG > 0) ? IFG - 1 : 0);
    localparam state_t END_ST = (IFG > 0) ? GAP : IDLE;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic [GW-1:0]    gap_cnt;
    logic             sent_inc;
    logic             drop_inc;

    logic             accept;
    logic             len_ok;
    logic             take;
    logic [LEN_W-1:0] rem_nx;

    assign bus.s_ready = reset &&
        (state == IDLE || state == DATA || state == FLUSH);

    assign accept = bus.s_valid & bus.s_ready;
    assign len_ok = len_legal(bus.s_len, MIN_L, MAX_L);

    // a forwarded byte is either a legal sop in IDLE or any DATA byte
    assign take = accept &&
        ((state == IDLE && bus.s_sop && len_ok) ||
         state == DATA);

    assign rem_nx = (state == IDLE) ?
        bus.s_len - LEN_W'(1) :
        rem - LEN_W'(1);

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            rem                   <= '0;
            gap_cnt               <= '0;
            sent_inc              <= 1'b0;
            drop_inc              <= 1'b0;
            bus.f_data_in         <= '0;
            bus.f_rec_data_valid  <= 1'b0;
            bus.f_rec_frame_valid <= 1'b0;
            bus.f_ctrl_in         <= '0;
            bus.f_hi_priority     <= 1'b0;
        end else begin
            bus.f_data_in         <= '0;
            bus.f_rec_data_valid  <= 1'b0;
            bus.f_rec_frame_valid <= 1'b0;
            bus.f_ctrl_in         <= '0;
            sent_inc              <= 1'b0;
            drop_inc              <= 1'b0;
            if (take) begin
                bus.f_data_in        <= bus.s_data;
                bus.f_rec_data_valid <= 1'b1;
                rem                  <= rem_nx;
                if (state == IDLE) begin
                    bus.f_rec_frame_valid <= 1'b1;
                    bus.f_ctrl_in     <= make_ctrl(bus.s_len);
                    bus.f_hi_priority <= bus.s_hi_pri;
                end
                if (rem_nx == '0) begin
                    sent_inc <= 1'b1;
                    if (bus.s_eop) begin
                        state   <= END_ST;
                        gap_cnt <= GAP_LD;
                    end else begin
                        state <= FLUSH;
                    end
                end else if (bus.s_eop) begin
                    state <= PAD;
                end else begin
                    state <= DATA;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        bus.f_hi_priority <= 1'b0;
                        if (accept && bus.s_sop) begin
                            drop_inc <= 1'b1;
                            if (bus.s_eop) begin
                                state   <= END_ST;
                                gap_cnt <= GAP_LD;
                            end else begin
                                state <= FLUSH;
                            end
                        end
                    end
                    DATA: begin
                    end
                    PAD: begin
                        bus.f_rec_data_valid <= 1'b1;
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state    <= END_ST;
                            gap_cnt  <= GAP_LD;
                            sent_inc <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (accept && bus.s_eop) begin
                            state   <= END_ST;
                            gap_cnt <= GAP_LD;
                        end
                    end
                    GAP: begin
                        bus.f_hi_priority <= 1'b0;
                        if (gap_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sat_counter16 u_cnt_sent (
        .clk   (clk_sys),
        .rst_n (reset),
        .inc   (sent_inc),
        .count (cnt_sent)
    );

    sat_counter16 u_cnt_dropped (
        .clk   (clk_sys),
        .rst_n (reset),
        .inc   (drop_inc),
        .count (cnt_dropped)
    );

    sat_counter16 u_cnt_discard (
        .clk   (clk_sys),
        .rst_n (reset),
        .inc   (bus.m_discard_en),
        .count (cnt_discard)
    );

endmodule

// File: doc/xmit_frame_feeder.md
XMIT_FRAME_FEEDER -- requirements
Module: xmit_frame_feeder

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes.
REQ-002 SHALL have parameter MAX_LEN, default 2047, maximum legal frame length in bytes.
REQ-003 SHALL have parameter IFG, default 4, idle cycles forced between frames on the f_* side.
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  upstream byte valid.
REQ-007 s_ready  out  1  feeder accepts the byte this cycle.
REQ-008 s_data  in  8  upstream byte.
REQ-009 s_sop / s_eop  in  1 each  first / last byte of a frame.
REQ-010 s_len  in  12  declared frame length; sampled only on an accepted s_sop byte.
REQ-011 s_hi_pri  in  1  frame priority; sampled with s_len.
REQ-012 f_data_in  out  8  byte to xmit stage.
REQ-013 f_rec_data_valid  out  1  f_data_in valid.
REQ-014 f_rec_frame_valid  out  1  one-cycle pulse with a frame's first byte.
REQ-015 f_ctrl_in  out  24  control word, valid while f_rec_frame_valid=1, else 0.
REQ-016 f_hi_priority  out  1  held for the whole frame.
REQ-017 m_discard_en  in  1  discard pulse from xmit stage.
REQ-018 cnt_sent / cnt_dropped / cnt_discard  out  16 each  statistics counters.

Function
REQ-019 States SHALL be IDLE, DATA, PAD, FLUSH, GAP.
REQ-020 Accept = s_valid & s_ready; s_ready SHALL be 1 in IDLE, DATA, FLUSH and 0 in PAD, GAP.
REQ-021 IDLE: accepted byte without s_sop SHALL be discarded silently.
REQ-022 IDLE: accepted s_sop with MIN_LEN <= s_len <= MAX_LEN -> DATA; byte forwarded with f_rec_frame_valid=1, f_ctrl_in = {s_len, s_len}; remaining counter loaded with s_len-1.
REQ-023 IDLE: accepted s_sop with illegal s_len -> FLUSH, nothing forwarded, cnt_dropped+1; an s_sop that is also s_eop -> GAP.
REQ-024 All f_* outputs SHALL be registered: an accepted byte appears exactly 1 cycle after acceptance.
REQ-025 DATA: each accepted byte forwarded, remaining decremented; an upstream stall SHALL produce f_rec_data_valid=0 cycles (no bubbles inserted otherwise).
REQ-026 DATA: last byte (remaining 0) coinciding with s_eop -> GAP, cnt_sent+1.
REQ-027 DATA: s_eop with remaining>0 -> PAD; PAD emits 8'h00 every cycle until declared length reached, then GAP, cnt_sent+1.
REQ-028 DATA: remaining reaches 0 without s_eop -> FLUSH; excess bytes accepted, not forwarded, until s_eop; cnt_sent+1.
REQ-029 FLUSH: accepted s_eop -> GAP.
REQ-030 GAP: exactly IFG cycles with f_rec_data_valid=0, then IDLE.
REQ-031 Emitted byte count per frame SHALL always equal the declared s_len.
REQ-032 s_sop in DATA SHALL be treated as a data byte (no restart).
REQ-033 cnt_discard SHALL increment on each m_discard_en cycle, independent of state.
REQ-034 All counters SHALL saturate at 16'hFFFF; simultaneous events on different counters all count.

Reset
REQ-035 reset low SHALL immediately force IDLE, all f_* outputs 0, counters 0, s_ready 0 while asserted.
REQ-036 reset mid-frame SHALL abandon the frame with no padding; first cycle after release s_ready=1.

Structure
REQ-037 Shared package xmit_pkg SHALL hold the state enum, CTRL_W=24, LEN_W=12, and the ctrl-word field positions ([23:12] length, [11:0] length copy).
REQ-038 Counters SHALL use one sub-module sat_counter16 instantiated three times.

Verification
REQ-039 Legal frame s_len=512, 512 bytes back-to-back, s_eop on last -> f_ctrl_in=24'h200200 with pulse, 512 valid bytes, 4 idle cycles, cnt_sent=1.
REQ-040 s_len=64, s_eop after byte 60 -> 60 data bytes then 4 bytes 8'h00, s_ready=0 during pad, cnt_sent=1.
REQ-041 s_len=64, 70 bytes sent -> 64 forwarded, 6 swallowed, next sop accepted only after 4 GAP cycles.
REQ-042 s_len=12'd10 and s_len=12'd2048-1 with MAX_LEN=100 -> nothing forwarded, cnt_dropped=2.
REQ-043 reset asserted at byte 200 of a 512 frame -> outputs 0 same cycle, next legal frame transmitted intact.
REQ-044 70000 m_discard_en pulses -> cnt_discard=16'hFFFF.
